// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder with req/resp handshakes, wait states and byte lanes.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses;
// when undefined, offending low address bits are ignored (forced alignment).
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [AW-1:0] idx;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] wshift;
    logic [31:0] mem_word_d;
    logic [3:0]  lane_mask;
    logic [31:0] rdata;
    logic        bad_f3;
    logic        misal;
    logic        err;
    logic        accept;
    logic        go_resp;
    logic        mem_we;
    logic        unused_addr_bits;

    assign req_ready  = (state_q == IDLE) && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign accept     = req_valid && req_ready;
    assign unused_addr_bits = ^{req_addr[31:AW+2], addr_q[31:AW+2]};

    // Decode the access that commits on the edge entering RESP; with zero wait states that is the incoming request
    always_comb begin
        a_we      = (state_q == IDLE) ? req_we     : we_q;
        a_f3      = (state_q == IDLE) ? req_funct3 : f3_q;
        a_addr    = (state_q == IDLE) ? req_addr   : addr_q;
        a_wdata   = (state_q == IDLE) ? req_wdata  : wdata_q;
        idx       = a_addr[AW+1:2];
        word      = mem_q[idx];
        bad_f3    = a_we ? (a_f3[2] || a_f3[1:0] == 2'b11) : (a_f3 == 3'b011 || a_f3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
        misal     = (a_f3[1:0] == 2'b01 && a_addr[0]) || (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00);
`else
        misal     = 1'b0;
`endif
        err       = bad_f3 || misal;
        off       = (a_f3[1:0] == 2'b00) ? a_addr[1:0] : (a_f3[1:0] == 2'b01) ? {a_addr[1], 1'b0} : 2'b00;
        shifted   = word >> {off, 3'b000};
        rdata     = (err || a_we) ? 32'h0 :
                    (a_f3 == 3'b000) ? {{24{shifted[7]}}, shifted[7:0]} :
                    (a_f3 == 3'b100) ? {24'h0, shifted[7:0]} :
                    (a_f3 == 3'b001) ? {{16{shifted[15]}}, shifted[15:0]} :
                    (a_f3 == 3'b101) ? {16'h0, shifted[15:0]} : shifted;
        lane_mask = ((a_f3[1:0] == 2'b00) ? 4'b0001 : (a_f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111) << off;
        wshift    = a_wdata << {off, 3'b000};
        for (int i = 0; i < 4; i++) mem_word_d[8*i +: 8] = lane_mask[i] ? wshift[8*i +: 8] : word[8*i +: 8];
        go_resp   = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd1);
        mem_we    = go_resp && a_we && !err;
    end

    // Next-state logic: capture on accept, count wait states, hold the response until it is taken
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? RESP : WAIT;
            end
            RESP: if (resp_ready) begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = rdata;
            resp_err_d   = err;
        end
    end

    // FSM and registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array: cleared by reset, byte-lane merged write on the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else if (mem_we) begin
            mem_q[idx] <= mem_word_d;
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 32, number of 32-bit words stored (power of two, 4..1024).
REQ-002 Parameter: WAIT_CYCLES, default 1, extra wait states between request acceptance and memory access (0..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
REQ-011 resp_valid  output  1  a response is present.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-014 resp_err  output  1  request was rejected (bad funct3 or misaligned).

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid=1 and req_ready=1.
REQ-017 On accept, we, funct3, addr and wdata SHALL be registered, and the FSM SHALL go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-018 WAIT SHALL count down from WAIT_CYCLES and enter RESP on the edge where the count reaches 0.
REQ-019 The memory access (read or byte-lane write) SHALL occur on the edge that enters RESP, so resp_valid rises exactly 1+WAIT_CYCLES cycles after accept.
REQ-020 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-021 No new request SHALL be accepted in the cycle of a response handshake, so there is a minimum of one IDLE cycle between transactions.
REQ-022 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored and the index wraps modulo DEPTH_WORDS.
REQ-023 SB SHALL write only lane addr[1:0]; SH SHALL write only lanes addr[1]*2..+1; SW SHALL write all four lanes; other lanes are unchanged.
REQ-024 LB/LH SHALL sign-extend the selected byte or halfword; LBU/LHU SHALL zero-extend it; LW returns the full word.
REQ-025 A load with funct3 in {011,110,111}, or a store with funct3 not in {000,001,010}, SHALL set resp_err=1 and resp_rdata=0, with no memory write.
REQ-026 A store response SHALL carry resp_rdata=0 and resp_err=0 unless an error is flagged.
REQ-027 req_valid while not in IDLE SHALL be ignored; the initiator must hold the request until req_ready.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, clear the wait counter, and set resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-029 req_ready SHALL be 0 while reset=1 and 1 on the first cycle after deassertion.
REQ-030 Reset SHALL clear all memory words to 0.
REQ-031 A store accepted but not yet committed when reset asserts SHALL be dropped.

Configuration
REQ-032 Macro DMEM_MISALIGN_CHECK_EN, when defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL give resp_err=1, resp_rdata=0 and no write.
REQ-033 When DMEM_MISALIGN_CHECK_EN is undefined: offending low address bits SHALL be treated as 0 (forced alignment), and resp_err is raised only by REQ-025.

Verification
REQ-034 Reset, then SW addr=0x8 wdata=0xDEADBEEF, then LW addr=0x8 -> rdata=0xDEADBEEF, err=0; resp_valid rises 2 cycles after each accept (WAIT_CYCLES=1).
REQ-035 SB addr=0x9 wdata=0x000000F0 over word 0xDEADBEEF, then LB 0x9 and LBU 0x9 -> memory word 0xDEADF0EF, LB=0xFFFFFFF0, LBU=0x000000F0.
REQ-036 Hold resp_ready=0 for 5 cycles during a load of 0x12345678 -> resp_valid and resp_rdata stay stable and req_ready stays 0; the handshake on cycle 6 returns the FSM to IDLE.
REQ-037 LW addr=0x6 -> with macro defined, err=1 and rdata=0; undefined, err=0 and rdata=word at 0x4.
REQ-038 Load funct3=111 -> err=1, rdata=0; store funct3=011 -> err=1 and a following LW shows memory unchanged.
REQ-039 Assert reset during WAIT of SW 0x0=0x55 -> resp_valid=0 and req_ready=0 while reset is high; a subsequent LW 0x0 returns 0; addr=0x80 (DEPTH_WORDS=32) aliases to 0x0.
